// File: rtl/hls_fp32_sub_pkg.sv
// Shared types and constants for the HLS fp32 sub core channel interfaces.
package hls_fp32_sub_pkg;
  localparam int FP32_W    = 32;
  localparam int CHN_DEPTH = 2;

  typedef logic [FP32_W-1:0] fp32_t;
  typedef logic [1:0]        chn_cnt_t;
endpackage

// File: rtl/hls_fp32_sub_core_chn_o_rsci_skid_if.sv
// chn_o handshake bundle: core-side write port plus downstream valid/ready port.
interface hls_fp32_sub_core_chn_o_rsci_skid_if;
  logic                     core_wen;
  logic                     chn_o_rsci_oswt;
  hls_fp32_sub_pkg::fp32_t  chn_o_rsci_d;
  logic                     chn_o_rsci_bawt;
  logic                     chn_o_rsci_wen_comp;
  hls_fp32_sub_pkg::fp32_t  chn_o_rsc_z;
  logic                     chn_o_rsc_lz;
  logic                     chn_o_rsc_vz;

  modport master (
    output core_wen, chn_o_rsci_oswt, chn_o_rsci_d, chn_o_rsc_vz,
    input  chn_o_rsci_bawt, chn_o_rsci_wen_comp, chn_o_rsc_z, chn_o_rsc_lz
  );
  modport slave (
    input  core_wen, chn_o_rsci_oswt, chn_o_rsci_d, chn_o_rsc_vz,
    output chn_o_rsci_bawt, chn_o_rsci_wen_comp, chn_o_rsc_z, chn_o_rsc_lz
  );
endinterface

// File: rtl/hls_fp32_sub_chn_o_skid_buf.sv
// Two-entry skid FIFO: storage, 1-bit wrapping pointers and occupancy count.
module hls_fp32_sub_chn_o_skid_buf
  import hls_fp32_sub_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  fp32_t wdata,
  output logic  full,
  output logic  empty,
  output fp32_t head
);
  fp32_t    mem_q [CHN_DEPTH];
  fp32_t    mem_d [CHN_DEPTH];
  logic     rd_ptr_q, rd_ptr_d;
  logic     wr_ptr_q, wr_ptr_d;
  chn_cnt_t count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHN_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == chn_cnt_t'(CHN_DEPTH));
  assign empty = (count_q == '0);
  // When empty, the slot behind rd_ptr is the last entry popped, so z holds its value.
  assign head  = empty ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];
endmodule

// File: rtl/hls_fp32_sub_core_chn_o_rsci.sv
// chn_o output interface of the fp32 sub core with a 2-entry skid buffer.
// Optional stall counter port enabled by defining FP32_SUB_CHN_O_PERF_EN.
module hls_fp32_sub_core_chn_o_rsci_skid
  import hls_fp32_sub_pkg::*;
(
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  hls_fp32_sub_core_chn_o_rsci_skid_if.slave chn
`ifdef FP32_SUB_CHN_O_PERF_EN
  ,output logic [15:0] chn_o_stall_cnt
`endif
);
  logic  full, empty, push, pop;
  fp32_t head;

  // bawt and lz depend only on buffer state, keeping vz/oswt off the return paths.
  assign push = chn.core_wen & chn.chn_o_rsci_oswt & ~full;
  assign pop  = ~empty & chn.chn_o_rsc_vz;

  hls_fp32_sub_chn_o_skid_buf u_buf (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (push),
    .pop   (pop),
    .wdata (chn.chn_o_rsci_d),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign chn.chn_o_rsci_bawt     = ~full;
  assign chn.chn_o_rsci_wen_comp = ~chn.chn_o_rsci_oswt | ~full;
  assign chn.chn_o_rsc_lz        = ~empty;
  assign chn.chn_o_rsc_z         = head;

`ifdef FP32_SUB_CHN_O_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (~empty && ~chn.chn_o_rsc_vz && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) stall_cnt_q <= '0;
    else                stall_cnt_q <= stall_cnt_d;
  end

  assign chn_o_stall_cnt = stall_cnt_q;
`endif
endmodule
